// File: rtl/hazard_scoreboard.sv
// Pipeline hazard scoreboard: tracks in-flight destinations after ID, selects operand
// bypass sources and raises load-use / late-result / multi-cycle stalls for IF/ID.
module hazard_scoreboard #(
    parameter int AW      = 5,
    parameter int NSRC    = 2,
    parameter int DEPTH   = 3,
    parameter int SW      = 2,
    parameter int CW      = 4,
    parameter int R0_ZERO = 1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               ID_VALID,
    input  logic               ID_WE,
    input  logic [AW-1:0]      ID_RD,
    input  logic [SW-1:0]      ID_RDY_STG,
    input  logic [NSRC*AW-1:0] ID_SRC,
    input  logic [NSRC-1:0]    ID_SRC_USED,
    input  logic               ID_MC,
    input  logic [CW-1:0]      ID_MC_CYC,
    input  logic               FLUSH,
    output logic               STALL,
    output logic [NSRC*SW-1:0] FWD_SEL,
    output logic               BUSY
);

    logic          r_v  [1:DEPTH];
    logic [AW-1:0] r_rd [1:DEPTH];
    logic [SW-1:0] r_rs [1:DEPTH];
    logic [CW-1:0] r_cnt;

    logic [NSRC-1:0] w_haz_vec;
    logic            w_busy;
    logic            w_go;
    logic            w_ins;
    logic            w_mc_issue;

    for (genvar gi = 0; gi < NSRC; gi++) begin : g_op
        logic [AW-1:0] w_src;
        logic [SW-1:0] w_sel;
        logic          w_haz;

        assign w_src = ID_SRC[gi*AW +: AW];

        // Scan oldest to youngest so the youngest matching stage overrides.
        always_comb begin
            w_sel = '0;
            w_haz = 1'b0;
            if (ID_VALID && ID_SRC_USED[gi] && !((R0_ZERO != 0) && (w_src == '0))) begin
                for (int k = DEPTH; k >= 1; k--) begin
                    if (r_v[k] && (r_rd[k] == w_src)) begin
                        if (SW'(k) >= r_rs[k]) begin
                            w_sel = SW'(k);
                            w_haz = 1'b0;
                        end else begin
                            w_sel = '0;
                            w_haz = 1'b1;
                        end
                    end
                end
            end
        end

        assign FWD_SEL[gi*SW +: SW] = w_sel;
        assign w_haz_vec[gi]        = w_haz;
    end

    assign w_busy     = (r_cnt != '0);
    assign BUSY       = w_busy;
    assign STALL      = ID_VALID && !FLUSH && ((|w_haz_vec) || w_busy);
    assign w_go       = ID_VALID && !STALL && !FLUSH;
    assign w_ins      = w_go && ID_WE;
    assign w_mc_issue = w_go && ID_MC;

    // Entries advance every cycle, even while ID is held, so hazard stalls always drain.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int k = 1; k <= DEPTH; k++) begin
                r_v[k]  <= 1'b0;
                r_rd[k] <= '0;
                r_rs[k] <= '0;
            end
        end else begin
            r_v[1]  <= w_ins;
            r_rd[1] <= ID_RD;
            r_rs[1] <= ID_RDY_STG;
            for (int k = 2; k <= DEPTH; k++) begin
                r_v[k]  <= (k == 2) ? (r_v[1] && !FLUSH) : r_v[k-1];
                r_rd[k] <= r_rd[k-1];
                r_rs[k] <= r_rs[k-1];
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt <= '0;
        end else if (w_mc_issue) begin
            r_cnt <= ID_MC_CYC;
        end else if (w_busy) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    a_rdy_stg_legal: assert property (@(posedge CLK) disable iff (RST)
        (ID_VALID && ID_WE) |-> ((ID_RDY_STG >= SW'(1)) && (ID_RDY_STG <= SW'(DEPTH))));

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard (default parameters, DEPTH=3).
module tb_hazard_scoreboard;

    logic       CLK;
    logic       RST;
    logic       ID_VALID;
    logic       ID_WE;
    logic [4:0] ID_RD;
    logic [1:0] ID_RDY_STG;
    logic [9:0] ID_SRC;
    logic [1:0] ID_SRC_USED;
    logic       ID_MC;
    logic [3:0] ID_MC_CYC;
    logic       FLUSH;
    logic       STALL;
    logic [3:0] FWD_SEL;
    logic       BUSY;

    int n_tests = 0;
    int n_fail  = 0;

    hazard_scoreboard dut (
        .CLK        (CLK),
        .RST        (RST),
        .ID_VALID   (ID_VALID),
        .ID_WE      (ID_WE),
        .ID_RD      (ID_RD),
        .ID_RDY_STG (ID_RDY_STG),
        .ID_SRC     (ID_SRC),
        .ID_SRC_USED(ID_SRC_USED),
        .ID_MC      (ID_MC),
        .ID_MC_CYC  (ID_MC_CYC),
        .FLUSH      (FLUSH),
        .STALL      (STALL),
        .FWD_SEL    (FWD_SEL),
        .BUSY       (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drv(input logic v, input logic we, input logic [4:0] rd,
                       input logic [1:0] rdy, input logic [4:0] s0, input logic [4:0] s1,
                       input logic [1:0] used, input logic mc, input logic [3:0] cyc,
                       input logic fl);
        ID_VALID    = v;
        ID_WE       = we;
        ID_RD       = rd;
        ID_RDY_STG  = rdy;
        ID_SRC      = {s1, s0};
        ID_SRC_USED = used;
        ID_MC       = mc;
        ID_MC_CYC   = cyc;
        FLUSH       = fl;
        #1;
    endtask

    task automatic drain();
        drv(0, 0, 0, 1, 0, 0, 2'b00, 0, 0, 0);
        repeat (4) tick();
    endtask

    task automatic test_reset();
        RST = 1'b1;
        drv(0, 0, 0, 1, 0, 0, 2'b00, 0, 0, 0);
        n_tests++;
        if (STALL !== 1'b0 || FWD_SEL !== 4'h0 || BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: stall=%b fwd=%h busy=%b, want 0 0 0", STALL, FWD_SEL, BUSY);
        end
        tick();
        RST = 1'b0;
        tick();
        drv(1, 0, 0, 1, 5'd3, 5'd4, 2'b11, 0, 0, 0);
        n_tests++;
        if (STALL !== 1'b0 || FWD_SEL !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_empty: stall=%b fwd=%h, want 0 0", STALL, FWD_SEL);
        end
    endtask

    task automatic test_alu_fwd();
        drv(1, 1, 5'd3, 1, 0, 0, 2'b00, 0, 0, 0);
        tick();
        drv(1, 0, 0, 1, 5'd3, 0, 2'b01, 0, 0, 0);
        n_tests++;
        if (FWD_SEL !== 4'b0001 || STALL !== 1'b0) begin
            n_fail++;
            $display("FAIL alu_fwd_s1: fwd=%b stall=%b, want 0001 0", FWD_SEL, STALL);
        end
        tick();
        n_tests++;
        if (FWD_SEL !== 4'b0010 || STALL !== 1'b0) begin
            n_fail++;
            $display("FAIL alu_fwd_s2: fwd=%b stall=%b, want 0010 0", FWD_SEL, STALL);
        end
        drain();
    endtask

    task automatic test_load_use();
        drv(1, 1, 5'd5, 2, 0, 0, 2'b00, 0, 0, 0);
        tick();
        // Reader also writes r9 and reads r9: a wrongful insert during the stall shows up.
        drv(1, 1, 5'd9, 1, 5'd9, 5'd5, 2'b11, 0, 0, 0);
        n_tests++;
        if (STALL !== 1'b1 || FWD_SEL !== 4'b0000) begin
            n_fail++;
            $display("FAIL load_use_stall: stall=%b fwd=%b, want 1 0000", STALL, FWD_SEL);
        end
        tick();
        n_tests++;
        if (STALL !== 1'b0 || FWD_SEL !== 4'b1000) begin
            n_fail++;
            $display("FAIL load_use_fwd2: stall=%b fwd=%b, want 0 1000", STALL, FWD_SEL);
        end
        tick();
        drv(1, 0, 0, 1, 5'd9, 5'd5, 2'b11, 0, 0, 0);
        n_tests++;
        if (STALL !== 1'b0 || FWD_SEL !== 4'b1101) begin
            n_fail++;
            $display("FAIL load_use_after: stall=%b fwd=%b, want 0 1101", STALL, FWD_SEL);
        end
        drain();
    endtask

    task automatic test_youngest();
        drv(1, 1, 5'd7, 1, 0, 0, 2'b00, 0, 0, 0);
        tick();
        tick();
        drv(1, 0, 0, 1, 5'd7, 5'd7, 2'b11, 0, 0, 0);
        n_tests++;
        if (FWD_SEL !== 4'b0101 || STALL !== 1'b0) begin
            n_fail++;
            $display("FAIL youngest: fwd=%b stall=%b, want 0101 0", FWD_SEL, STALL);
        end
        drain();
        drv(1, 1, 5'd0, 1, 0, 0, 2'b00, 0, 0, 0);
        tick();
        drv(1, 1, 5'd0, 2, 0, 0, 2'b00, 0, 0, 0);
        tick();
        drv(1, 0, 0, 1, 5'd0, 5'd0, 2'b11, 0, 0, 0);
        n_tests++;
        if (FWD_SEL !== 4'b0000 || STALL !== 1'b0) begin
            n_fail++;
            $display("FAIL r0_zero: fwd=%b stall=%b, want 0000 0", FWD_SEL, STALL);
        end
        drain();
        drv(1, 0, 5'd4, 1, 0, 0, 2'b00, 0, 0, 0);
        tick();
        drv(1, 0, 0, 1, 5'd4, 5'd4, 2'b11, 0, 0, 0);
        n_tests++;
        if (FWD_SEL !== 4'b0000 || STALL !== 1'b0) begin
            n_fail++;
            $display("FAIL we0_nomatch: fwd=%b stall=%b, want 0000 0", FWD_SEL, STALL);
        end
        drain();
    endtask

    task automatic test_multicycle();
        drv(1, 0, 0, 1, 0, 0, 2'b00, 1, 4'd3, 0);
        n_tests++;
        if (STALL !== 1'b0 || BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL mc_issue: stall=%b busy=%b, want 0 0", STALL, BUSY);
        end
        tick();
        drv(1, 0, 0, 1, 0, 0, 2'b00, 0, 0, 0);
        for (int c = 0; c < 3; c++) begin
            n_tests++;
            if (STALL !== 1'b1 || BUSY !== 1'b1) begin
                n_fail++;
                $display("FAIL mc_busy[%0d]: stall=%b busy=%b, want 1 1", c, STALL, BUSY);
            end
            tick();
        end
        n_tests++;
        if (STALL !== 1'b0 || BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL mc_done: stall=%b busy=%b, want 0 0", STALL, BUSY);
        end
        drv(1, 0, 0, 1, 0, 0, 2'b00, 1, 4'd0, 0);
        tick();
        drv(1, 0, 0, 1, 0, 0, 2'b00, 0, 0, 0);
        n_tests++;
        if (STALL !== 1'b0 || BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL mc_zero: stall=%b busy=%b, want 0 0", STALL, BUSY);
        end
        drain();
    endtask

    task automatic test_flush();
        drv(1, 1, 5'd5, 2, 0, 0, 2'b00, 0, 0, 0);
        tick();
        drv(1, 1, 5'd6, 1, 5'd5, 0, 2'b01, 0, 0, 1);
        n_tests++;
        if (STALL !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_nostall: stall=%b, want 0", STALL);
        end
        tick();
        drv(1, 0, 0, 1, 5'd5, 5'd6, 2'b11, 0, 0, 0);
        n_tests++;
        if (FWD_SEL !== 4'b0000 || STALL !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_dropped: fwd=%b stall=%b, want 0000 0", FWD_SEL, STALL);
        end
        drain();
    endtask

    task automatic test_reset_mid_stall();
        drv(1, 1, 5'd3, 1, 0, 0, 2'b00, 1, 4'd3, 0);
        tick();
        drv(1, 0, 0, 1, 5'd3, 0, 2'b01, 0, 0, 0);
        tick();
        n_tests++;
        if (STALL !== 1'b1 || BUSY !== 1'b1 || FWD_SEL !== 4'b0010) begin
            n_fail++;
            $display("FAIL mid_pre: stall=%b busy=%b fwd=%b, want 1 1 0010", STALL, BUSY,
                     FWD_SEL);
        end
        RST = 1'b1;
        #1;
        n_tests++;
        if (STALL !== 1'b0 || BUSY !== 1'b0 || FWD_SEL !== 4'b0000) begin
            n_fail++;
            $display("FAIL mid_rst: stall=%b busy=%b fwd=%b, want 0 0 0000", STALL, BUSY,
                     FWD_SEL);
        end
        #1;
        RST = 1'b0;
        tick();
        n_tests++;
        if (STALL !== 1'b0 || BUSY !== 1'b0 || FWD_SEL !== 4'b0000) begin
            n_fail++;
            $display("FAIL mid_fresh: stall=%b busy=%b fwd=%b, want 0 0 0000", STALL, BUSY,
                     FWD_SEL);
        end
        drv(1, 1, 5'd3, 1, 0, 0, 2'b00, 0, 0, 0);
        tick();
        drv(1, 0, 0, 1, 5'd3, 0, 2'b01, 0, 0, 0);
        n_tests++;
        if (STALL !== 1'b0 || FWD_SEL !== 4'b0001) begin
            n_fail++;
            $display("FAIL mid_refwd: stall=%b fwd=%b, want 0 0001", STALL, FWD_SEL);
        end
        drain();
    endtask

    initial begin
        RST = 1'b1;
        drv(0, 0, 0, 1, 0, 0, 2'b00, 0, 0, 0);
        test_reset();
        test_alu_fwd();
        test_load_use();
        test_youngest();
        test_multicycle();
        test_flush();
        test_reset_mid_stall();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
